exu_alu_dpath_arb: RTL

//  Shares the single EXU ALU datapath (adder/shifter/logic) between N_REQ requesters:

---
 rtl/exu_alu_dpath_arb_pkg.sv | 34 +++
 rtl/exu_alu_dpath_arb_rr_arb_n.sv | 33 +++
 rtl/exu_alu_dpath_arb.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/exu_alu_dpath_arb_pkg.sv
// Shared constants and types for the EXU ALU datapath arbiter.
package exu_alu_dpath_arb_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned N_REQ    = 4;
  localparam int unsigned ALU_OP_W = 12;
  localparam int unsigned ID_W     = 2;

  // One-hot ALU op bit positions
  localparam int unsigned OP_ADD    = 0;
  localparam int unsigned OP_SUB    = 1;
  localparam int unsigned OP_SLT    = 2;
  localparam int unsigned OP_SLTU   = 3;
  localparam int unsigned OP_XOR    = 4;
  localparam int unsigned OP_OR     = 5;
  localparam int unsigned OP_AND    = 6;
  localparam int unsigned OP_SLL    = 7;
  localparam int unsigned OP_SRL    = 8;
  localparam int unsigned OP_SRA    = 9;
  localparam int unsigned OP_CMP_EQ = 10;
  localparam int unsigned OP_CMP_LT = 11;

  // Requester ids
  localparam logic [ID_W-1:0] REQ_RGLR = 2'd0;
  localparam logic [ID_W-1:0] REQ_BJP  = 2'd1;
  localparam logic [ID_W-1:0] REQ_AGU  = 2'd2;
  localparam logic [ID_W-1:0] REQ_MDV  = 2'd3;

  typedef enum logic [0:0] {
    StUnlocked,
    StLocked
  } lock_state_e;

endpackage

// File: rtl/exu_alu_dpath_arb_rr_arb_n.sv
// Rotating-priority picker: first valid index at or after the pointer, with wrap.
module exu_alu_dpath_arb_rr_arb_n #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_gnt_id,
  output logic             o_gnt_valid
);

  // Scan ptr, ptr+1, ... and take the first valid requester
  always_comb begin
    logic            w_found;
    logic [ID_W-1:0] w_idx;
    w_found     = 1'b0;
    w_idx       = '0;
    o_gnt       = '0;
    o_gnt_id    = '0;
    o_gnt_valid = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = ID_W'((32'(i_ptr) + k) % N_REQ);
      if (!w_found && i_valid[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_id     = w_idx;
        o_gnt_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exu_alu_dpath_arb.sv
// Shares the EXU ALU datapath between requesters: round-robin grant with optional
// multi-beat lock, and a one-entry response register tagged with the owner id.
module exu_alu_dpath_arb #(
  parameter int unsigned XLEN  = exu_alu_dpath_arb_pkg::XLEN,
  parameter int unsigned N_REQ = exu_alu_dpath_arb_pkg::N_REQ,
  parameter int unsigned OP_W  = exu_alu_dpath_arb_pkg::ALU_OP_W,
  parameter int unsigned ID_W  = exu_alu_dpath_arb_pkg::ID_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic [N_REQ-1:0]      i_req_valid,
  output logic [N_REQ-1:0]      o_req_ready,
  input  logic [N_REQ*XLEN-1:0] i_req_op1,
  input  logic [N_REQ*XLEN-1:0] i_req_op2,
  input  logic [N_REQ*OP_W-1:0] i_req_op,
  input  logic [N_REQ-1:0]      i_req_lock,
  output logic [XLEN-1:0]       o_dp_op1,
  output logic [XLEN-1:0]       o_dp_op2,
  output logic [OP_W-1:0]       o_dp_op,
  input  logic [XLEN-1:0]       i_dp_res,
  output logic                  o_rsp_valid,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [XLEN-1:0]       o_rsp_res,
  input  logic                  i_rsp_ready,
  output logic                  o_locked
);

  import exu_alu_dpath_arb_pkg::*;

  lock_state_e     r_state, w_state_nxt;
  logic [ID_W-1:0] r_lock_id, w_lock_id_nxt;
  logic [ID_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic [XLEN-1:0] r_rsp_res;

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_id;
  logic             w_gnt_valid;
  logic             w_gnt_lock;
  logic             w_slot_free;
  logic             w_accept;

  // While locked only the lock owner may be granted
  always_comb begin
    w_elig = i_req_valid;
    if (r_state == StLocked) begin
      w_elig = i_req_valid & ({{(N_REQ-1){1'b0}}, 1'b1} << r_lock_id);
    end
  end

  exu_alu_dpath_arb_rr_arb_n #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arb (
    .i_valid     (w_elig),
    .i_ptr       (r_rr_ptr),
    .o_gnt       (w_gnt),
    .o_gnt_id    (w_gnt_id),
    .o_gnt_valid (w_gnt_valid)
  );

  assign w_slot_free = !r_rsp_valid || i_rsp_ready;
  // Flush and reset both suppress the accept
  assign w_accept    = w_gnt_valid && w_slot_free && !i_flush && !i_rst;
  assign w_gnt_lock  = |(i_req_lock & w_gnt);
  assign o_req_ready = w_gnt & {N_REQ{w_accept}};

  // Operand mux from the granted requester; all zero with no grant
  always_comb begin
    o_dp_op1 = '0;
    o_dp_op2 = '0;
    o_dp_op  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        o_dp_op1 = i_req_op1[i*XLEN +: XLEN];
        o_dp_op2 = i_req_op2[i*XLEN +: XLEN];
        o_dp_op  = i_req_op[i*OP_W +: OP_W];
      end
    end
  end

  // Lock FSM next state; the rr pointer only advances on a beat that leaves us unlocked
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    w_rr_ptr_nxt  = r_rr_ptr;
    if (i_flush) begin
      w_state_nxt = StUnlocked;
    end else if (w_accept) begin
      unique case (r_state)
        StUnlocked, StLocked: begin
          if (w_gnt_lock) begin
            w_state_nxt   = StLocked;
            w_lock_id_nxt = w_gnt_id;
          end else begin
            w_state_nxt  = StUnlocked;
            w_rr_ptr_nxt = (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
          end
        end
        default: w_state_nxt = StUnlocked;
      endcase
    end
  end

  // Lock FSM and arbitration state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StUnlocked;
      r_lock_id <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
    end
  end

  // One-entry response slot; flush drops it even if being consumed or refilled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_res   <= '0;
    end else if (i_flush) begin
      r_rsp_valid <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt_id;
      r_rsp_res   <= i_dp_res;
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_res   = r_rsp_res;
  assign o_locked    = (r_state == StLocked);

endmodule
